// File: rtl/kv_txn_scheduler.sv
// rtl/kv_txn_scheduler.sv - round-robin front end issuing one transaction at a time to the KV BRAM store
// Grants one requester, drives the store for a fixed latency, then returns the result tagged with the requester ID.
`timescale 1ns/1ps
module kv_txn_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int KEY_WIDTH     = 32,
  parameter int VALUE_WIDTH   = 32,
  parameter int STORE_LATENCY = 3,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [2*NUM_REQ-1:0]           req_op,
  input  logic [KEY_WIDTH*NUM_REQ-1:0]   req_key,
  input  logic [VALUE_WIDTH*NUM_REQ-1:0] req_value,
  input  logic [NUM_REQ-1:0]             req_kind,
  output logic                           ram_enable,
  output logic                           write_enable,
  output logic [1:0]                     store_signal,
  output logic [KEY_WIDTH-1:0]           store_key,
  output logic [VALUE_WIDTH-1:0]         store_transact_value,
  output logic                           store_transact_kind,
  input  logic [VALUE_WIDTH-1:0]         store_updated_value,
  input  logic [31:0]                    store_value_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [VALUE_WIDTH-1:0]         rsp_value,
  output logic [31:0]                    rsp_addr,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [15:0]                    txn_count
);

  localparam int CNT_W = (STORE_LATENCY > 1) ? $clog2(STORE_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ID_W-1:0]        r_last_grant;
  logic [CNT_W-1:0]       r_wait_cnt;
  logic [1:0]             r_store_signal;
  logic [KEY_WIDTH-1:0]   r_store_key;
  logic [VALUE_WIDTH-1:0] r_store_value;
  logic                   r_store_kind;
  logic [ID_W-1:0]        r_rsp_id;
  logic [VALUE_WIDTH-1:0] r_rsp_value;
  logic [31:0]            r_rsp_addr;
  logic                   r_rsp_err;
  logic [15:0]            r_txn_count;

  logic                   w_grant_vld;
  logic [ID_W-1:0]        w_grant_idx;
  logic [ID_W:0]          w_cand;
  logic [1:0]             w_grant_op;

  // Scan farthest-first so the nearest valid index after last_grant is the final assignment.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_cand = {1'b0, r_last_grant} + (ID_W+1)'(i);
      if (w_cand >= (ID_W+1)'(NUM_REQ)) w_cand = w_cand - (ID_W+1)'(NUM_REQ);
      if (req_valid[w_cand[ID_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand[ID_W-1:0];
      end
    end
  end

  assign w_grant_op = req_op[2*w_grant_idx +: 2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_vld) w_state_nxt = (w_grant_op == 2'd3) ? S_RESP : S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (r_wait_cnt == '0) w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    ram_enable   = 1'b0;
    write_enable = 1'b0;
    rsp_valid    = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (w_grant_vld) req_ready[w_grant_idx] = 1'b1;
      S_ISSUE: begin
        ram_enable   = 1'b1;
        write_enable = (r_store_signal != 2'd0);
      end
      S_WAIT:  ram_enable = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant   <= ID_W'(NUM_REQ-1);
      r_wait_cnt     <= '0;
      r_store_signal <= '0;
      r_store_key    <= '0;
      r_store_value  <= '0;
      r_store_kind   <= 1'b0;
      r_rsp_id       <= '0;
      r_rsp_value    <= '0;
      r_rsp_addr     <= '0;
      r_rsp_err      <= 1'b0;
      r_txn_count    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_grant_vld) begin
          r_last_grant <= w_grant_idx;
          r_rsp_id     <= w_grant_idx;
          // Illegal ops answer directly and leave the store-facing registers untouched.
          if (w_grant_op == 2'd3) begin
            r_rsp_err   <= 1'b1;
            r_rsp_value <= '0;
            r_rsp_addr  <= '0;
          end else begin
            r_store_signal <= w_grant_op;
            r_store_key    <= req_key[KEY_WIDTH*w_grant_idx +: KEY_WIDTH];
            r_store_value  <= req_value[VALUE_WIDTH*w_grant_idx +: VALUE_WIDTH];
            r_store_kind   <= req_kind[w_grant_idx];
          end
        end
        S_ISSUE: r_wait_cnt <= CNT_W'(STORE_LATENCY-1);
        S_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_rsp_value <= store_updated_value;
            r_rsp_addr  <= store_value_addr;
            r_rsp_err   <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt - CNT_W'(1);
          end
        end
        S_RESP: if (rsp_ready) r_txn_count <= r_txn_count + 16'd1;
        default: ;
      endcase
    end
  end

  assign store_signal         = r_store_signal;
  assign store_key            = r_store_key;
  assign store_transact_value = r_store_value;
  assign store_transact_kind  = r_store_kind;
  assign rsp_id               = r_rsp_id;
  assign rsp_value            = r_rsp_value;
  assign rsp_addr             = r_rsp_addr;
  assign rsp_err              = r_rsp_err;
  assign txn_count            = r_txn_count;

endmodule

// File: tb/tb_kv_txn_scheduler.sv
// tb/tb_kv_txn_scheduler.sv - scoreboard bench for kv_txn_scheduler with a behavioural store model
`timescale 1ns/1ps
module tb_kv_txn_scheduler;
  localparam int NUM_REQ = 4;
  localparam int KW = 32;
  localparam int VW = 32;
  localparam int LAT = 3;
  localparam int IDW = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [NUM_REQ-1:0] req_valid = '0;
  logic [NUM_REQ-1:0] req_ready;
  logic [2*NUM_REQ-1:0] req_op = '0;
  logic [KW*NUM_REQ-1:0] req_key = '0;
  logic [VW*NUM_REQ-1:0] req_value = '0;
  logic [NUM_REQ-1:0] req_kind = '0;
  logic ram_enable, write_enable;
  logic [1:0] store_signal;
  logic [KW-1:0] store_key;
  logic [VW-1:0] store_transact_value;
  logic store_transact_kind;
  logic [VW-1:0] store_updated_value = '0;
  logic [31:0] store_value_addr = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [IDW-1:0] rsp_id;
  logic [VW-1:0] rsp_value;
  logic [31:0] rsp_addr;
  logic rsp_err, busy;
  logic [15:0] txn_count;

  kv_txn_scheduler #(.NUM_REQ(NUM_REQ), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .STORE_LATENCY(LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
    .req_value(req_value), .req_kind(req_kind),
    .ram_enable(ram_enable), .write_enable(write_enable), .store_signal(store_signal),
    .store_key(store_key), .store_transact_value(store_transact_value),
    .store_transact_kind(store_transact_kind), .store_updated_value(store_updated_value),
    .store_value_addr(store_value_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_value(rsp_value),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err), .busy(busy), .txn_count(txn_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned id;
    logic [1:0] op;
    logic [KW-1:0] key;
    logic [VW-1:0] val;
    logic kind;
  } req_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [VW-1:0] val;
    logic [31:0] addr;
    logic err;
  } exp_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  req_t pend[$];
  req_t cur[NUM_REQ];
  exp_t exp_q[$];
  int grant_log[$];
  logic [NUM_REQ-1:0] acc = '0;
  logic [VW-1:0] ref_kv[logic [KW-1:0]];
  logic [VW-1:0] mem[logic [KW-1:0]];
  int grant_cyc = 0, first_rsp_cyc = 0, en_cycles = 0, we_cycles = 0;
  logic rv_prev = 1'b0;
  logic [VW-1:0] last_val = '0;
  logic last_err = 1'b0;

  // store model state
  logic prev_en = 1'b0;
  int issue_cyc = 0;
  logic [1:0] issue_sig = '0;
  logic [KW-1:0] issue_key = '0;
  logic [VW-1:0] issue_val = '0;
  logic issue_kind = 1'b0;
  logic [VW-1:0] sv_v;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t model(req_t r);
    exp_t e;
    logic [VW-1:0] v;
    v = ref_kv.exists(r.key) ? ref_kv[r.key] : '0;
    e.id = IDW'(r.id);
    e.err = 1'b0;
    e.addr = {r.key[29:0], 2'b00};
    case (r.op)
      2'd0: e.val = v;
      2'd1: begin
        v = r.kind ? v - r.val : v + r.val;
        ref_kv[r.key] = v;
        e.val = v;
      end
      2'd2: begin
        ref_kv[r.key] = r.val;
        e.val = r.val;
      end
      default: begin
        e.val = '0;
        e.addr = '0;
        e.err = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Store: result appears only on the sample edge LAT cycles after the command cycle.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_en = 1'b0;
    end else begin
      if (ram_enable && !prev_en) begin
        issue_cyc = cyc;
        issue_sig = store_signal;
        issue_key = store_key;
        issue_val = store_transact_value;
        issue_kind = store_transact_kind;
      end
      prev_en = ram_enable;
      if (ram_enable && cyc == issue_cyc + LAT) begin
        sv_v = mem.exists(issue_key) ? mem[issue_key] : '0;
        if (issue_sig == 2'd1) sv_v = issue_kind ? sv_v - issue_val : sv_v + issue_val;
        if (issue_sig == 2'd2) sv_v = issue_val;
        if (issue_sig != 2'd0) mem[issue_key] = sv_v;
        store_updated_value = sv_v;
        store_value_addr = {issue_key[29:0], 2'b00};
      end else begin
        store_updated_value = 32'hDEAD_0000 | 32'(cyc);
        store_value_addr = 32'hBAD0_0000 | 32'(cyc);
      end
    end
  end

  // Grant capture and scoreboard pop.
  always @(negedge clock) begin
    if (!reset_n) begin
      rv_prev = 1'b0;
    end else begin
      if (req_ready != '0) begin
        total++;
        if (!$onehot(req_ready)) begin
          bad++;
          $display("FAIL req_ready_onehot got=%b", req_ready);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_ready[i]) begin
            acc[i] = 1'b1;
            grant_log.push_back(i);
            grant_cyc = cyc;
            exp_q.push_back(model(cur[i]));
          end
        end
      end
      if (ram_enable) en_cycles++;
      if (write_enable) we_cycles++;
      if (rsp_valid && !rv_prev) first_rsp_cyc = cyc;
      rv_prev = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected got id=%0d val=%0d", rsp_id, rsp_value);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_id, rsp_value, rsp_addr, rsp_err} !== {e.id, e.val, e.addr, e.err}) begin
            bad++;
            $display("FAIL rsp got id=%0d val=%0d addr=%h err=%b required id=%0d val=%0d addr=%h err=%b",
                     rsp_id, rsp_value, rsp_addr, rsp_err, e.id, e.val, e.addr, e.err);
          end
        end
        last_val = rsp_value;
        last_err = rsp_err;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        req_valid[i] = 1'b0;
        acc[i] = 1'b0;
      end
      if (!req_valid[i]) begin
        for (int k = 0; k < pend.size(); k++) begin
          if (pend[k].id == i) begin
            cur[i] = pend[k];
            pend.delete(k);
            req_op[2*i +: 2] = cur[i].op;
            req_key[KW*i +: KW] = cur[i].key;
            req_value[VW*i +: VW] = cur[i].val;
            req_kind[i] = cur[i].kind;
            req_valid[i] = 1'b1;
            break;
          end
        end
      end
    end
  endtask

  task automatic submit(input int id, input logic [1:0] op, input logic [KW-1:0] key,
                        input logic [VW-1:0] val, input logic kind);
    req_t r;
    r.id = id; r.op = op; r.key = key; r.val = val; r.kind = kind;
    pend.push_back(r);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || pend.size() != 0 || req_valid != '0 || busy) && n < 400) begin
      step();
      n++;
    end
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL %s_timeout got=busy required=idle", name);
    end
  endtask

  task automatic wait_grant(input int g0, input string name);
    int n = 0;
    while (grant_log.size() <= g0 && n < 100) begin
      step();
      n++;
    end
    total++;
    if (grant_log.size() <= g0) begin
      bad++;
      $display("FAIL %s_grant_timeout got=none required=grant", name);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = '0;
    acc = '0;
    pend.delete();
    exp_q.delete();
    rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b required=0", busy); end
    total++; if (ram_enable !== 1'b0 || write_enable !== 1'b0) begin bad++; $display("FAIL rst_ram got=%b%b required=00", ram_enable, write_enable); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b required=0", rsp_valid); end
    total++; if (txn_count !== 16'd0) begin bad++; $display("FAIL rst_txn_count got=%0d required=0", txn_count); end
    total++; if ({store_signal, store_key, store_transact_value, store_transact_kind} !== '0) begin bad++; $display("FAIL rst_store got key=%0d required=0", store_key); end
    total++; if ({rsp_id, rsp_value, rsp_addr, rsp_err} !== '0) begin bad++; $display("FAIL rst_rsp got val=%0d required=0", rsp_value); end
    total++; if (req_ready !== '0) begin bad++; $display("FAIL rst_req_ready got=%b required=0", req_ready); end
  endtask

  task automatic test_lookup();
    int g0 = grant_log.size();
    int we0 = we_cycles;
    submit(2, 2'd0, 249, 0, 1'b0);
    wait_grant(g0, "lookup");
    wait_idle("lookup");
    total++; if (grant_log.size() - g0 !== 1 || grant_log[g0] !== 2) begin bad++; $display("FAIL lookup_grant got n=%0d required one grant to 2", grant_log.size() - g0); end
    total++; if (first_rsp_cyc - grant_cyc !== LAT + 2) begin bad++; $display("FAIL lookup_latency got=%0d required=%0d", first_rsp_cyc - grant_cyc, LAT + 2); end
    total++; if (we_cycles - we0 !== 0) begin bad++; $display("FAIL lookup_we got=%0d required=0", we_cycles - we0); end
    total++; if (issue_key !== 249) begin bad++; $display("FAIL lookup_store_key got=%0d required=249", issue_key); end
    total++; if (last_val !== 1000) begin bad++; $display("FAIL lookup_value got=%0d required=1000", last_val); end
  endtask

  task automatic test_transact();
    int we0 = we_cycles;
    submit(0, 2'd1, 249, 10, 1'b0);
    wait_idle("credit");
    total++; if (we_cycles - we0 !== 1) begin bad++; $display("FAIL credit_we got=%0d required=1", we_cycles - we0); end
    total++; if (last_val !== 1010) begin bad++; $display("FAIL credit_value got=%0d required=1010", last_val); end
    submit(0, 2'd1, 249, 10, 1'b1);
    wait_idle("debit");
    total++; if (last_val !== 1000) begin bad++; $display("FAIL debit_value got=%0d required=1000", last_val); end
  endtask

  task automatic test_illegal();
    int g0 = grant_log.size();
    int en0 = en_cycles;
    submit(1, 2'd3, 55, 9, 1'b0);
    wait_grant(g0, "illegal");
    wait_idle("illegal");
    total++; if (first_rsp_cyc - grant_cyc !== 1) begin bad++; $display("FAIL illegal_latency got=%0d required=1", first_rsp_cyc - grant_cyc); end
    total++; if (en_cycles !== en0) begin bad++; $display("FAIL illegal_ram_enable got=%0d required=0", en_cycles - en0); end
    total++; if (last_err !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b required=1", last_err); end
  endtask

  task automatic test_backpressure();
    logic [IDW+VW+33:0] snap;
    int n = 0;
    int tc0;
    rsp_ready = 1'b0;
    submit(3, 2'd0, 249, 0, 1'b0);
    while (!rsp_valid && n < 50) begin step(); n++; end
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp_timeout got=%b required=1", rsp_valid); end
    snap = {rsp_valid, rsp_id, rsp_value, rsp_addr, rsp_err};
    submit(0, 2'd0, 7, 0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      total++; if ({rsp_valid, rsp_id, rsp_value, rsp_addr, rsp_err} !== snap) begin bad++; $display("FAIL bp_stable got val=%0d required=%0d", rsp_value, snap[VW+32:33]); end
      total++; if (req_ready !== '0) begin bad++; $display("FAIL bp_req_ready got=%b required=0", req_ready); end
    end
    tc0 = txn_count;
    rsp_ready = 1'b1;
    step();
    total++; if (txn_count !== 16'(tc0 + 1)) begin bad++; $display("FAIL bp_complete got=%0d required=%0d", txn_count, tc0 + 1); end
    wait_idle("bp");
  endtask

  task automatic test_round_robin();
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    grant_log.delete();
    for (int i = 0; i < NUM_REQ; i++) submit(i, 2'd2, 32'(100 + i), 32'(7 * i + 1), 1'b0);
    for (int i = 0; i < NUM_REQ; i++) submit(i, 2'd0, 32'(100 + i), 0, 1'b0);
    wait_idle("rr");
    for (int k = 0; k < 8; k++) begin
      total++;
      if (k >= grant_log.size() || grant_log[k] !== exp_order[k]) begin
        bad++;
        $display("FAIL rr_order_%0d got=%0d required=%0d", k, (k < grant_log.size()) ? grant_log[k] : -1, exp_order[k]);
      end
    end
    total++; if (txn_count !== 16'd8) begin bad++; $display("FAIL rr_txn_count got=%0d required=8", txn_count); end
  endtask

  task automatic test_reset_mid();
    int g0 = grant_log.size();
    int vcnt = 0;
    submit(2, 2'd0, 249, 0, 1'b0);
    wait_grant(g0, "rmid");
    step();
    total++; if (ram_enable !== 1'b1 || write_enable !== 1'b0) begin bad++; $display("FAIL rmid_in_wait got=%b%b required=10", ram_enable, write_enable); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (ram_enable !== 1'b0 || write_enable !== 1'b0) begin bad++; $display("FAIL rmid_ram got=%b%b required=00", ram_enable, write_enable); end
    total++; if ({busy, rsp_valid, req_ready, txn_count} !== '0) begin bad++; $display("FAIL rmid_outputs got busy=%b txn=%0d required=0", busy, txn_count); end
    total++; if ({store_signal, store_key, rsp_value, rsp_addr} !== '0) begin bad++; $display("FAIL rmid_regs got key=%0d required=0", store_key); end
    req_valid = '0;
    acc = '0;
    pend.delete();
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (rsp_valid) vcnt++;
    end
    total++; if (vcnt !== 0) begin bad++; $display("FAIL rmid_no_rsp got=%0d required=0", vcnt); end
    g0 = grant_log.size();
    submit(2, 2'd0, 249, 0, 1'b0);
    submit(0, 2'd0, 249, 0, 1'b0);
    wait_grant(g0, "rmid_next");
    total++; if (grant_log.size() <= g0 || grant_log[g0] !== 0) begin bad++; $display("FAIL rmid_next_grant got=%0d required=0", (grant_log.size() > g0) ? grant_log[g0] : -1); end
    wait_idle("rmid");
  endtask

  initial begin
    mem[249] = 1000;
    ref_kv[249] = 1000;
    test_reset();
    test_lookup();
    test_transact();
    test_illegal();
    test_backpressure();
    test_round_robin();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/kv_txn_scheduler.md
# kv_txn_scheduler

Front-end controller for the hashed key-value BRAM store (two hash tables plus value memory). It accepts key/value transactions from NUM_REQ requesters, round-robin arbitrates among them, and drives one command at a time into the store's `signal`/`key`/`transact_value`/`transact_kind` inputs. It waits the store's fixed read latency, then returns `updated_value`/`value_addr` to the winning requester, tagged with its ID. Only one transaction is in flight at a time, so hash-table read-modify-write hazards on the same key cannot occur.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- KEY_WIDTH, 32, key width
- VALUE_WIDTH, 32, transaction value / balance width
- STORE_LATENCY, 3, cycles from command cycle to valid store outputs (≥1)

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_op  in  2*NUM_REQ  per-requester opcode (0 lookup, 1 transact, 2 insert, 3 illegal)
- req_key  in  KEY_WIDTH*NUM_REQ  per-requester key
- req_value  in  VALUE_WIDTH*NUM_REQ  per-requester transact value
- req_kind  in  NUM_REQ  per-requester kind (0 credit, 1 debit)
- ram_enable  out  1  store enable
- write_enable  out  1  store write strobe
- store_signal  out  2  to store `signal`
- store_key  out  KEY_WIDTH  to store `key`
- store_transact_value  out  VALUE_WIDTH  to store `transact_value`
- store_transact_kind  out  1  to store `transact_kind`
- store_updated_value  in  VALUE_WIDTH  from store `updated_value`
- store_value_addr  in  32  from store `value_addr`
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  clog2(NUM_REQ)  requester index of the response
- rsp_value  out  VALUE_WIDTH  captured updated_value
- rsp_addr  out  32  captured value_addr
- rsp_err  out  1  illegal opcode
- busy  out  1  state != IDLE
- txn_count  out  16  completed responses; wraps 0xFFFF→0

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, grant the first valid index searching from (last_grant+1) mod NUM_REQ upward. req_ready[grant] is driven combinationally high in this cycle only. On that edge, capture op/key/value/kind/id and update last_grant.
- IDLE transitions: op 0–2 → ISSUE; op 3 → RESP with rsp_err=1, rsp_value=0, rsp_addr=0. The store is never touched for op 3.
- ISSUE (1 cycle): ram_enable=1; store_* driven from captured fields; write_enable=1 for ops 1 and 2, 0 for op 0. Load wait counter with STORE_LATENCY-1; → WAIT.
- WAIT: ram_enable=1, write_enable=0, store_* held. Decrement the counter. At zero, capture store_updated_value/store_value_addr on that edge, rsp_err=0; → RESP.
- RESP: rsp_valid=1, all rsp_* stable. On rsp_valid&&rsp_ready: txn_count++, → IDLE. No new grant in the same cycle.
- store_* outputs hold their last value outside ISSUE/WAIT; ram_enable=0 outside ISSUE/WAIT.
- Requests arriving while busy are ignored (req_ready=0). Requesters hold req_* stable until accepted.

## Timing

- Reset (async assert, sync deassert) values: state IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), all outputs 0, wait counter 0, txn_count 0.
- Grant at cycle T; ISSUE at T+1; store outputs sampled at end of cycle T+1+STORE_LATENCY; rsp_valid high from T+2+STORE_LATENCY.
- With rsp_ready tied high: back in IDLE at T+3+STORE_LATENCY. Peak rate is one transaction per STORE_LATENCY+3 cycles.
- Illegal op: rsp_valid at T+1.
- rsp_ready low: stay in RESP indefinitely with outputs stable.
- reset_n low mid-transaction: in-flight transaction dropped, no response, ram_enable/write_enable drop immediately.
- Round-robin fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 other grants.

## Test plan

- Reset, then req 2 lookup (op 0, key 249). Required: req_ready[2] pulse; one ISSUE cycle with write_enable=0 and store_key=249. With STORE_LATENCY=3, rsp_valid 5 cycles after grant, rsp_id=2, rsp_value equals the stored value for key 249.
- Req 0 transact (op 1, key 249, value 10, kind 0). Required: write_enable high for exactly 1 cycle; rsp_value = prior value+10. A following debit of 10 returns the original value.
- All 4 requesters valid continuously for 8 transactions. Required: grant order 0,1,2,3,0,1,2,3; txn_count=8.
- Req 1 op 3. Required: rsp_valid next cycle, rsp_err=1, ram_enable never asserted.
- rsp_ready held low for 10 cycles in RESP. Required: rsp_* stable, req_ready all 0; completes 1 cycle after rsp_ready rises.
- reset_n pulsed low during WAIT. Required: all outputs 0 immediately, no response emitted. The next grant goes to requester 0.
